fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ------------------------------------------------------------
// fetch_pkg: shared types and defaults for the fetch controller
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int unsigned DEF_MEM_BYTES = 400;
  localparam logic [31:0] DEF_RESET_PC  = 32'd0;
  localparam int unsigned DEF_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Word-aligned and the whole word lies inside the memory.
  function automatic logic addr_in_range(input logic [31:0] pc, input int unsigned mem_bytes);
    return (pc[1:0] == 2'b00) && (({1'b0, pc} + 33'd4) <= 33'(mem_bytes));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ------------------------------------------------------------
// fetch_fifo: DEPTH-entry prefetch buffer with push/pop/flush
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CAP);
  assign do_pop  = pop && !empty;
  // On a full buffer the slot freed by the pop is the one being written.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && rst_n && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ------------------------------------------------------------
// fetch_ctrl: sequential instruction fetch with prefetch buffer,
// redirect flush and bad-address halt. Rev 1.0
// ------------------------------------------------------------
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int unsigned DEPTH     = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] read_adress,
  input  logic [31:0] instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nxt;
  logic        fault_nxt;
  logic [31:0] fault_pc_nxt;
  logic        addr_ok;
  logic        push;
  logic        pop;
  logic        flush;
  logic        full;
  logic        empty;
  entry_t      head;
  entry_t      tail;

  assign read_adress = fetch_pc;
  assign addr_ok     = addr_in_range(fetch_pc, MEM_BYTES);
  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready && !redirect;
  assign tail        = '{pc: fetch_pc, instr: instruction};
  // Idle/flushed outputs read as zero rather than stale buffer contents.
  assign out_pc      = out_valid ? head.pc    : '0;
  assign out_instr   = out_valid ? head.instr : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      fault    <= fault_nxt;
      fault_pc <= fault_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    fault_nxt    = fault;
    fault_pc_nxt = fault_pc;
    push         = 1'b0;
    flush        = 1'b0;
    if (redirect) begin
      flush        = 1'b1;
      fetch_pc_nxt = redirect_pc;
      fault_nxt    = 1'b0;
      state_nxt    = en ? ST_FETCH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          // A bad address halts even if EN drops in the same cycle.
          if (!addr_ok) begin
            state_nxt    = ST_HALT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = fetch_pc;
          end else begin
            if (!full || pop) begin
              push         = 1'b1;
              fetch_pc_nxt = fetch_pc + 32'd4;
            end
            if (!en) state_nxt = ST_IDLE;
          end
        end
        ST_HALT: begin
          state_nxt = ST_HALT;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (tail),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ------------------------------------------------------------
// tb_fetch_ctrl: directed + random bench with a queue-based model
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

  localparam int unsigned MEM    = 400;
  localparam int unsigned DEPTH  = 2;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] read_adress;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] seed;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fault_pc;

  fetch_ctrl #(.MEM_BYTES(MEM), .RESET_PC(32'd0), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .read_adress (read_adress),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .fault       (fault),
    .fault_pc    (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s ^ {a[15:0], a[31:16]};
  endfunction

  assign instruction = word_at(read_adress, seed);

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    if (!rst_n) begin
      q.delete();
      m_mode = M_IDLE; m_pc = 32'd0; m_fault = 1'b0; m_fault_pc = 32'd0;
    end else if (redirect) begin
      q.delete();
      m_pc = redirect_pc; m_fault = 1'b0;
      m_mode = en ? M_FETCH : M_IDLE;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (m_mode == M_FETCH) begin
        if (m_pc % 4 != 0 || longint'(m_pc) + 4 > longint'(MEM)) begin
          m_mode = M_HALT; m_fault = 1'b1; m_fault_pc = m_pc;
        end else begin
          if (q.size() < DEPTH) begin
            q.push_back('{pc: m_pc, ins: word_at(m_pc, seed)});
            m_pc = m_pc + 32'd4;
          end
          if (!en) m_mode = M_IDLE;
        end
      end else if (m_mode == M_IDLE && en) begin
        m_mode = M_FETCH;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("out_pc", out_pc, (q.size() > 0) ? q[0].pc : 32'd0);
    chk("out_instr", out_instr, (q.size() > 0) ? q[0].ins : 32'd0);
    chk("read_adress", read_adress, m_pc);
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("fault_pc", fault_pc, m_fault_pc);
  endtask

  task automatic step(input bit r_n, input bit e, input bit rdy, input bit rd, input logic [31:0] rpc);
    rst_n = r_n; en = e; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    seed = $urandom;
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    // Reset values
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_read_adress", read_adress, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming from reset with consumer always ready
    step(1, 1, 1, 0, 0);
    chk("first_valid_latency", {31'd0, out_valid}, 32'd0);
    step(1, 1, 1, 0, 0);
    chk("stream_pc0", out_pc, 32'd0);
    chk("stream_ins0", out_instr, word_at(32'd0, seed));
    step(1, 1, 1, 0, 0);
    chk("stream_pc4", out_pc, 32'd4);
    step(1, 1, 1, 0, 0);
    chk("stream_pc8", out_pc, 32'd8);

    // Backpressure: buffer fills at two entries, head stable
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    chk("bp_read_adress", read_adress, 32'd8);
    chk("bp_head_pc", out_pc, 32'd0);
    step(1, 1, 1, 0, 0);
    chk("bp_drain_pc4", out_pc, 32'd4);
    step(1, 1, 1, 0, 0);
    chk("bp_drain_pc8", out_pc, 32'd8);

    // Redirect flushes a loaded buffer
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 32'd40);
    chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    step(1, 1, 1, 0, 0);
    chk("redir_pc40", out_pc, 32'd40);
    step(1, 1, 1, 0, 0);
    chk("redir_pc44", out_pc, 32'd44);

    // Run off the end of memory
    step(1, 1, 1, 1, 32'd380);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_fault_pc", fault_pc, 32'd400);
    step(1, 1, 1, 0, 0);
    chk("halt_holds_pc", read_adress, 32'd400);
    step(1, 1, 1, 1, 32'd0);
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    step(1, 1, 1, 0, 0);
    chk("resume_pc0", out_pc, 32'd0);

    // Misaligned redirect target
    step(1, 1, 1, 1, 32'd6);
    step(1, 1, 1, 0, 0);
    chk("misalign_fault_pc", fault_pc, 32'd6);
    chk("misalign_valid", {31'd0, out_valid}, 32'd0);

    // Reset beats a redirect with a full buffer
    step(1, 1, 0, 1, 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'd40);
    chk("rst_over_redir_pc", read_adress, 32'd0);
    chk("rst_over_redir_valid", {31'd0, out_valid}, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: rpc = 32'($urandom_range(0, 99)) * 32'd4;
        1: rpc = 32'd380;
        2: rpc = 32'($urandom_range(0, 99)) * 32'd4 + 32'($urandom_range(1, 3));
        default: rpc = ($urandom_range(0, 1) == 0) ? 32'd400 : 32'hFFFF_FFFC;
      endcase
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 6,
           rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
